// File: rtl/reaction_sequencer.sv
// ---------------------------------------------------------------------------
// reaction_sequencer
//
// Runs one two-player reaction round: a P1 turn, then a P2 turn, then a
// one-cycle judge strobe. Each turn goes through four phases: a 2-cycle clear,
// a random wait, a GO phase and a report hold. The block drives the flag/led
// command interface of the timing/judging controller. It detects the active
// player's press, which may be early (a foul), on time, or absent (a timeout).
//
// Parameters
//   DLY_MIN   minimum WAIT length in cycles
//   DLY_MASK  mask applied to the LFSR to form the random extra wait
//   TIMEOUT   GO cycles before an automatic report when nobody presses
//   HOLD      cycles the report flag is held (>= 1)
//
// Ports
//   clk    in   system clock (1 ms tick in the product)
//   rst    in   asynchronous, active-high reset
//   start  in   start button, asynchronous level
//   btn1   in   player 1 button, asynchronous level
//   btn2   in   player 2 button, asynchronous level
//   flag   out  command: 0 clear, 1 running, 2 P1 result, 3 P2 result
//   led    out  [0] P1 turn lamp, [1] P2 turn lamp, [2] GO lamp
//   judge  out  one-cycle compare strobe after the P2 report
//   foul   out  high during REPORT when the turn ended by an early press
//
// Handshake: there is no valid/ready pair. The controller treats a change of
// flag as the command. flag is stable for whole phases, and judge is a
// single-cycle strobe.
//
// All outputs are registered straight from a decode of the current state.
// They therefore trail the state register by one cycle. This gives the
// documented press latency: an input first sampled at edge N changes flag at
// edge N+3.
// ---------------------------------------------------------------------------
module reaction_sequencer #(
    parameter int          DLY_MIN  = 1000,
    parameter logic [15:0] DLY_MASK = 16'h03FF,
    parameter int          TIMEOUT  = 999,
    parameter int          HOLD     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btn1,
    input  logic       btn2,
    output logic [3:0] flag,
    output logic [2:0] led,
    output logic       judge,
    output logic       foul
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_WAIT   = 3'd2,
        S_GO     = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam logic [15:0] RC_LAST   = 16'(TIMEOUT - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD - 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    state_t      state;
    state_t      state_nxt;

    // Input conditioning: bit0 = first sync FF, bit1 = synchronized level,
    // bit2 = history of the synchronized level.
    logic [2:0]  start_s;
    logic [2:0]  btn1_s;
    logic [2:0]  btn2_s;
    logic        start_e;
    logic        btn1_e;
    logic        btn2_e;
    logic        act_e;

    logic [15:0] lfsr;
    logic        lfsr_fb;

    logic        turn;        // 0 = P1, 1 = P2
    logic [15:0] dly;         // remaining WAIT cycles
    logic [15:0] rc;          // GO cycle counter
    logic [15:0] cnt;         // phase counter for CLEAR and REPORT
    logic        foul_r;      // current turn ended by an early press
    logic        judge_pend;  // first IDLE cycle after the P2 report

    logic [3:0]  flag_c;
    logic [2:0]  led_c;
    logic        judge_c;
    logic        foul_c;

    // ------------------------------------------------------------------
    // Synchronizers and rising-edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_s <= 3'b000;
            btn1_s  <= 3'b000;
            btn2_s  <= 3'b000;
        end else begin
            start_s <= {start_s[1:0], start};
            btn1_s  <= {btn1_s[1:0],  btn1};
            btn2_s  <= {btn2_s[1:0],  btn2};
        end
    end

    assign start_e = start_s[1] & ~start_s[2];
    assign btn1_e  = btn1_s[1]  & ~btn1_s[2];
    assign btn2_e  = btn2_s[1]  & ~btn2_s[2];

    // Only the player whose turn it is can end the turn.
    assign act_e = turn ? btn2_e : btn1_e;

    // ------------------------------------------------------------------
    // Free-running Fibonacci LFSR, taps 16,14,13,11. The seed is non-zero,
    // so the all-zero lock-up state is never reached.
    // ------------------------------------------------------------------
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_e) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt == 16'd1) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A press wins over an expiry in the same cycle. The dly<=1
                // test also covers a zero load when DLY_MIN is 0.
                if (act_e) begin
                    state_nxt = S_REPORT;
                end else if (dly <= 16'd1) begin
                    state_nxt = S_GO;
                end
            end
            S_GO: begin
                if (act_e || (rc == RC_LAST)) begin
                    state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = turn ? S_IDLE : S_CLEAR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Turn datapath: turn select, wait/GO counters, phase counter, foul and
    // judge bookkeeping. It follows the same decisions as the next-state
    // logic.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turn       <= 1'b0;
            dly        <= 16'd0;
            rc         <= 16'd0;
            cnt        <= 16'd0;
            foul_r     <= 1'b0;
            judge_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    judge_pend <= 1'b0;
                    if (state_nxt == S_CLEAR) begin
                        turn <= 1'b0;
                        cnt  <= 16'd0;
                    end
                end
                S_CLEAR: begin
                    cnt    <= cnt + 16'd1;
                    foul_r <= 1'b0;
                    if (cnt == 16'd1) begin
                        dly <= 16'(DLY_MIN) + (lfsr & DLY_MASK);
                    end
                end
                S_WAIT: begin
                    dly <= dly - 16'd1;
                    if (state_nxt == S_REPORT) begin
                        foul_r <= 1'b1;
                        cnt    <= 16'd0;
                    end else if (state_nxt == S_GO) begin
                        rc <= 16'd0;
                    end
                end
                S_GO: begin
                    rc <= rc + 16'd1;
                    if (state_nxt == S_REPORT) begin
                        foul_r <= 1'b0;
                        cnt    <= 16'd0;
                    end
                end
                S_REPORT: begin
                    cnt <= cnt + 16'd1;
                    if (state_nxt == S_CLEAR) begin
                        turn <= 1'b1;
                        cnt  <= 16'd0;
                    end else if (state_nxt == S_IDLE) begin
                        judge_pend <= 1'b1;
                    end
                end
                default: begin
                    cnt <= 16'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        flag_c  = 4'd0;
        led_c   = 3'b000;
        judge_c = 1'b0;
        foul_c  = 1'b0;
        case (state)
            S_IDLE: begin
                judge_c = judge_pend;
            end
            S_CLEAR: begin
                led_c = {1'b0, turn, ~turn};
            end
            S_WAIT: begin
                flag_c = 4'd1;
                led_c  = {1'b0, turn, ~turn};
            end
            S_GO: begin
                flag_c = 4'd1;
                led_c  = {1'b1, turn, ~turn};
            end
            S_REPORT: begin
                // The GO lamp keeps its last value. The controller reads it
                // to choose between the foul value and the stopped count.
                flag_c = turn ? 4'd3 : 4'd2;
                led_c  = {~foul_r, turn, ~turn};
                foul_c = foul_r;
            end
            default: begin
                flag_c = 4'd0;
            end
        endcase
    end

    // Registered outputs; no combinational path from any input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag  <= 4'd0;
            led   <= 3'b000;
            judge <= 1'b0;
            foul  <= 1'b0;
        end else begin
            flag  <= flag_c;
            led   <= led_c;
            judge <= judge_c;
            foul  <= foul_c;
        end
    end

endmodule

// File: tb/tb_reaction_sequencer.sv
// Bench for reaction_sequencer. Expected output runs are pushed as
// {judge, foul, led, flag, length}; length 0 means any length. The monitor
// checks each finished run of a constant output vector against the queue.
module tb_reaction_sequencer;

  localparam int DLY_MIN  = 8;
  localparam int TIMEOUT  = 20;
  localparam int HOLD     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       btn1;
  logic       btn2;
  logic [3:0] flag;
  logic [2:0] led;
  logic       judge;
  logic       foul;

  logic [8:0] cur_vec;
  assign cur_vec = {judge, foul, led, flag};

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [8:0]  prev_vec;
  int          run_len;

  reaction_sequencer #(
    .DLY_MIN  (DLY_MIN),
    .DLY_MASK (16'h0003),
    .TIMEOUT  (TIMEOUT),
    .HOLD     (HOLD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .btn1  (btn1),
    .btn2  (btn2),
    .flag  (flag),
    .led   (led),
    .judge (judge),
    .foul  (foul)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] ent(input logic j, input logic f, input logic [2:0] l,
                                      input logic [3:0] fl, input int len);
    return {j, f, l, fl, 8'(len)};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (cur_vec !== prev_vec) begin
        logic [16:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_run got vec=%h len=%0d", prev_vec, run_len);
        end else begin
          e = exp_q.pop_front();
          if ((prev_vec !== e[16:8]) || ((e[7:0] != 8'd0) && (run_len != int'(e[7:0])))) begin
            errors++;
            $display("FAIL run got vec=%h len=%0d exp vec=%h len=%0d",
                     prev_vec, run_len, e[16:8], e[7:0]);
          end
        end
        prev_vec = cur_vec;
        run_len  = 1;
      end else begin
        run_len++;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_vec(input logic [8:0] v, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (cur_vec === v) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_%s got vec=%h exp vec=%h", name, cur_vec, v);
    end
  endtask

  task automatic press(input int p, input int hold);
    if (p == 0) btn1 = 1'b1; else btn2 = 1'b1;
    tick(hold);
    if (p == 0) btn1 = 1'b0; else btn2 = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(3);
    start = 1'b0;
  endtask

  function automatic logic [2:0] lamp(input int p);
    return (p == 0) ? 3'b001 : 3'b010;
  endfunction

  // mode 0: press m cycles after GO seen, 1: foul, 2: no press
  task automatic push_turn(input int p, input int mode, input int m);
    logic [2:0] l;
    logic [3:0] fl;
    l  = lamp(p);
    fl = (p == 0) ? 4'd2 : 4'd3;
    exp_q.push_back(ent(1'b0, 1'b0, l, 4'd0, 2));
    if (mode == 1) begin
      exp_q.push_back(ent(1'b0, 1'b0, l, 4'd1, 5));
      exp_q.push_back(ent(1'b0, 1'b1, l, fl, HOLD));
    end else begin
      exp_q.push_back(ent(1'b0, 1'b0, l, 4'd1, 0));
      exp_q.push_back(ent(1'b0, 1'b0, l | 3'b100, 4'd1, (mode == 2) ? TIMEOUT : m + 4));
      exp_q.push_back(ent(1'b0, 1'b0, l | 3'b100, fl, HOLD));
    end
  endtask

  task automatic push_match(input int md1, input int m1, input int md2, input int m2);
    exp_q.push_back(ent(1'b0, 1'b0, 3'b000, 4'd0, 0));
    push_turn(0, md1, m1);
    push_turn(1, md2, m2);
    exp_q.push_back(ent(1'b1, 1'b0, 3'b000, 4'd0, 1));
  endtask

  task automatic do_turn(input int p, input int mode, input int m);
    if (mode == 1) begin
      wait_vec({2'b00, lamp(p), 4'd1}, "wait");
      tick(1);
      press(p, 3);
    end else begin
      wait_vec({2'b00, lamp(p) | 3'b100, 4'd1}, "go");
      if (mode == 0) begin
        tick(m);
        press(p, 3);
      end
    end
  endtask

  task automatic finish_match();
    wait_vec({1'b1, 1'b0, 3'b000, 4'd0}, "judge");
    tick(3);
  endtask

  task automatic run_match(input int md1, input int m1, input int md2, input int m2);
    push_match(md1, m1, md2, m2);
    pulse_start();
    do_turn(0, md1, m1);
    do_turn(1, md2, m2);
    finish_match();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; btn1 = 1'b0; btn2 = 1'b0;
    tick(3);
    checks++;
    if (cur_vec !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got vec=%h exp vec=%h", cur_vec, 9'd0);
    end
    rst = 1'b0;
    tick(3);

    // reset in the middle of a GO phase
    pulse_start();
    wait_vec({2'b00, 3'b101, 4'd1}, "go_pre_reset");
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cur_vec !== 9'd0) begin
      errors++;
      $display("FAIL reset_async got vec=%h exp vec=%h", cur_vec, 9'd0);
    end
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      btn1 = (i % 4) < 2;
      tick(1);
      checks++;
      if (cur_vec !== 9'd0) begin
        errors++;
        $display("FAIL idle_after_reset got vec=%h exp vec=%h", cur_vec, 9'd0);
      end
    end
    btn1 = 1'b0;
    tick(3);

    @(posedge clk);
    #1;
    prev_vec = cur_vec;
    run_len  = 0;
    mon_en   = 1'b1;
    tick(2);

    // normal match
    run_match(0, 5, 0, 9);
    // P1 foul, P2 normal
    run_match(1, 0, 0, 5);
    // P2 timeout
    run_match(0, 2, 2, 0);

    // wrong player button and late start are ignored
    push_match(0, 10, 0, 3);
    pulse_start();
    wait_vec({2'b00, 3'b001, 4'd1}, "wp_wait");
    btn2 = 1'b1; tick(2); btn2 = 1'b0; tick(2);
    wait_vec({2'b00, 3'b101, 4'd1}, "wp_go");
    for (int i = 0; i < 10; i++) begin
      btn2  = (i % 4) < 2;
      start = (i >= 2) && (i < 5);
      tick(1);
    end
    btn2 = 1'b0; start = 1'b0;
    press(0, 3);
    do_turn(1, 0, 3);
    finish_match();

    // held button from IDLE, released and re-pressed in GO
    push_match(0, 4, 0, 2);
    btn1 = 1'b1;
    tick(2);
    pulse_start();
    wait_vec({2'b00, 3'b101, 4'd1}, "held_go");
    btn1 = 1'b0;
    tick(4);
    press(0, 3);
    do_turn(1, 0, 2);
    finish_match();

    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained got %0d entries exp 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
